wb_arbiter: RTL

Write-back arbiter and pending-write tracker for the dual-issue superscalar core. It collects completed results from the three execution units (ALU1, ALU2, MMU) through one-entry holding buffers and grants at most two of them per cycle onto the two register-file write ports. It also maintains a 32-bit pending-write table: bits are set at issue and cleared at write-back, and the issue scoreboard reads the table for hazard checks.

---
 rtl/wb_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter (3 units -> 2 register-file ports) with a 32-bit pending-write table
// Ports: clk/rst (sync, active-high), flush; iss0/iss1 issue (valid, addr) set pending bits;
//        aluo/alut/mmu *_wb_valid/addr/data in, *_wb_ready out; rf_w0/rf_w1 ena/addr/data
//        registered write ports; pending_table bit r set while a write to xr is outstanding.
// Optional: YSYX22040228_WB_AGE_ARB_EN selects age-first arbitration instead of fixed priority.
module wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              iss0_valid,
    input  logic [ADDR_W-1:0] iss0_addr,
    input  logic              iss1_valid,
    input  logic [ADDR_W-1:0] iss1_addr,
    input  logic              aluo_wb_valid,
    input  logic [ADDR_W-1:0] aluo_wb_addr,
    input  logic [DATA_W-1:0] aluo_wb_data,
    output logic              aluo_wb_ready,
    input  logic              alut_wb_valid,
    input  logic [ADDR_W-1:0] alut_wb_addr,
    input  logic [DATA_W-1:0] alut_wb_data,
    output logic              alut_wb_ready,
    input  logic              mmu_wb_valid,
    input  logic [ADDR_W-1:0] mmu_wb_addr,
    input  logic [DATA_W-1:0] mmu_wb_data,
    output logic              mmu_wb_ready,
    output logic              rf_w0_ena,
    output logic [ADDR_W-1:0] rf_w0_addr,
    output logic [DATA_W-1:0] rf_w0_data,
    output logic              rf_w1_ena,
    output logic [ADDR_W-1:0] rf_w1_addr,
    output logic [DATA_W-1:0] rf_w1_data,
    output logic [31:0]       pending_table
);
    // buffer index 0 = MMU, 1 = ALU1, 2 = ALU2 (fixed-priority order)
    logic [2:0]        w_in_v, w_rdy, w_load, w_gnt, r_bv;
    logic [ADDR_W-1:0] w_in_a [3];
    logic [DATA_W-1:0] w_in_d [3];
    logic [ADDR_W-1:0] r_ba [3];
    logic [DATA_W-1:0] r_bd [3];
    logic [3:0]        w_key [3];
    logic              w_g0_v, w_g1_v;
    logic [1:0]        w_g0, w_g1;
    logic [31:0]       r_pend, w_set, w_clr;

    assign w_in_v = {alut_wb_valid, aluo_wb_valid, mmu_wb_valid};
    assign w_in_a[0] = mmu_wb_addr;
    assign w_in_a[1] = aluo_wb_addr;
    assign w_in_a[2] = alut_wb_addr;
    assign w_in_d[0] = mmu_wb_data;
    assign w_in_d[1] = aluo_wb_data;
    assign w_in_d[2] = alut_wb_data;

    assign w_rdy = {3{~rst}} & (~r_bv | w_gnt);
    assign {alut_wb_ready, aluo_wb_ready, mmu_wb_ready} = w_rdy;

`ifdef YSYX22040228_WB_AGE_ARB_EN
    logic [1:0] r_age [3];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || flush || w_load[i]) begin
                r_age[i] <= 2'd0;
            end else if (r_bv[i] && !w_gnt[i] && r_age[i] != 2'd3) begin
                r_age[i] <= r_age[i] + 2'd1;
            end
        end
    end
`endif

    // rank key: age (when enabled) above a fixed tie-break favouring lower index
    always_comb begin
        w_g0_v = 1'b0;
        w_g0   = 2'd0;
        w_g1_v = 1'b0;
        w_g1   = 2'd0;
        w_load = 3'b0;
        w_gnt  = 3'b0;
        for (int i = 0; i < 3; i++) begin
`ifdef YSYX22040228_WB_AGE_ARB_EN
            w_key[i] = {r_age[i], 2'(3 - i)};
`else
            w_key[i] = {2'd0, 2'(3 - i)};
`endif
            w_load[i] = w_in_v[i] && w_rdy[i] && (w_in_a[i] != '0);
        end
        for (int i = 0; i < 3; i++) begin
            if (r_bv[i] && (!w_g0_v || w_key[i] > w_key[w_g0])) begin
                w_g0_v = 1'b1;
                w_g0   = 2'(i);
            end
        end
        // second grant skips anything aimed at the first grant's register
        for (int i = 0; i < 3; i++) begin
            if (r_bv[i] && w_g0_v && 2'(i) != w_g0 && r_ba[i] != r_ba[w_g0] &&
                (!w_g1_v || w_key[i] > w_key[w_g1])) begin
                w_g1_v = 1'b1;
                w_g1   = 2'(i);
            end
        end
        if (w_g0_v) w_gnt[w_g0] = 1'b1;
        if (w_g1_v) w_gnt[w_g1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || flush) begin
                r_bv[i] <= 1'b0;
            end else if (w_load[i]) begin
                r_bv[i] <= 1'b1;
                r_ba[i] <= w_in_a[i];
                r_bd[i] <= w_in_d[i];
            end else if (w_gnt[i]) begin
                r_bv[i] <= 1'b0;
            end
        end
    end

    assign w_set = ((32'(iss0_valid) << iss0_addr) | (32'(iss1_valid) << iss1_addr)) & ~32'd1;
    assign w_clr = (32'(rf_w0_ena) << rf_w0_addr) | (32'(rf_w1_ena) << rf_w1_addr);
    assign pending_table = r_pend;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rf_w0_ena  <= 1'b0;
            rf_w0_addr <= '0;
            rf_w0_data <= '0;
            rf_w1_ena  <= 1'b0;
            rf_w1_addr <= '0;
            rf_w1_data <= '0;
            r_pend     <= '0;
        end else begin
            rf_w0_ena <= w_g0_v;
            rf_w1_ena <= w_g1_v;
            if (w_g0_v) begin
                rf_w0_addr <= r_ba[w_g0];
                rf_w0_data <= r_bd[w_g0];
            end
            if (w_g1_v) begin
                rf_w1_addr <= r_ba[w_g1];
                rf_w1_data <= r_bd[w_g1];
            end
            // set after clear so a same-cycle issue keeps the bit
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end
endmodule
